// File: rtl/voice_pkg.sv
// Shared types and constants for the multi-voice mixer: FSM state encoding,
// default sample/voice sizing and a ceil-log2 helper for derived widths.
package voice_pkg;

  typedef enum logic [1:0] {
    VM_IDLE = 2'd0,
    VM_SCAN = 2'd1,
    VM_DONE = 2'd2
  } vm_state_t;

  localparam int VM_M_DEFAULT  = 12;
  localparam int VM_NV_DEFAULT = 4;

  // Never returns less than 1, so a select bus always has at least one bit.
  function automatic int vm_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/mix_scale.sv
// Combinational scaling of the mix accumulator to an M-bit sample.
// VOICE_MIXER_SAT_EN selects unity gain with full-scale clamp; otherwise a true average.
module mix_scale
  import voice_pkg::*;
#(
  parameter int M  = VM_M_DEFAULT,
  parameter int SW = 2
) (
  input  logic [M+SW-1:0] acc,
  output logic [M-1:0]    out
);

`ifdef VOICE_MIXER_SAT_EN
  always_comb begin
    out = acc[M-1:0];
    if (|acc[M+SW-1:M]) out = '1;
  end
`else
  always_comb begin
    out = acc[M+SW-1:SW];
  end
`endif

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: scans each voice on the select bus, sums the
// enabled ones and emits one scaled sample per tick. Scaling build: VOICE_MIXER_SAT_EN.
//
// state   | meaning
// IDLE    | waiting for sample_tick, sel and acc parked at 0
// SCAN    | reading voice sel, accumulating if enabled
// DONE    | publishing scaled acc on out with out_valid
module voice_mixer
  import voice_pkg::*;
#(
  parameter int M  = VM_M_DEFAULT,
  parameter int NV = VM_NV_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  input  logic [NV-1:0]           voice_en,
  input  logic [M-1:0]            in,
  output logic [vm_clog2(NV)-1:0] sel,
  output logic [M-1:0]            out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int SW = vm_clog2(NV);
  localparam int AW = M + SW;

  localparam logic [1:0] ST_IDLE = VM_IDLE;
  localparam logic [1:0] ST_SCAN = VM_SCAN;
  localparam logic [1:0] ST_DONE = VM_DONE;

  logic [1:0]    state;
  logic [AW-1:0] acc;
  logic [M-1:0]  scaled;

  mix_scale #(.M(M), .SW(SW)) u_scale (
    .acc (acc),
    .out (scaled)
  );

  // busy decodes the state register only, so it stays a registered output.
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_tick && (state != ST_IDLE)) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          sel <= '0;
          acc <= '0;
          if (sample_tick) state <= ST_SCAN;
        end
        ST_SCAN: begin
          acc <= acc + (voice_en[sel] ? AW'(in) : '0);
          if (sel == SW'(NV - 1)) begin
            sel   <= '0;
            state <= ST_DONE;
          end else begin
            sel <= sel + 1'b1;
          end
        end
        ST_DONE: begin
          out       <= scaled;
          out_valid <= 1'b1;
          acc       <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          sel   <= '0;
          acc   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (M=12, NV=4); expected mixes are hand-computed
// for both the averaging build and the VOICE_MIXER_SAT_EN build.
module tb_voice_mixer;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic [3:0]  voice_en;
  logic [11:0] in;
  logic [1:0]  sel;
  logic [11:0] out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  logic [11:0] vin [4];

  int total;
  int passed;

  voice_mixer #(.M(12), .NV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .in          (in),
    .sel         (sel),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Voice generators answer the select bus combinationally.
  always_comb in = vin[sel];

  // Drive tick ahead of the next rising edge, then sample 1 time unit after it.
  task automatic step(input logic t);
    sample_tick = t;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic set_voices(input int a, input int b, input int c, input int d);
    vin[0] = 12'(a);
    vin[1] = 12'(b);
    vin[2] = 12'(c);
    vin[3] = 12'(d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(1'b0);
    step(1'b1);
    total++; if (out !== 12'd0) $display("FAIL reset_out got %0d exp 0", out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else passed++;
    total++; if (sel !== 2'd0) $display("FAIL reset_sel got %0d exp 0", sel); else passed++;
    rst_n = 1'b1;
    step(1'b0);
  endtask

  task automatic test_basic;
    logic [11:0] exp_out;
    int pulses;
`ifdef VOICE_MIXER_SAT_EN
    exp_out = 12'd1000;
`else
    exp_out = 12'd250;
`endif
    set_voices(100, 200, 300, 400);
    voice_en = 4'b1111;
    pulses = 0;
    step(1'b1);
    for (int k = 0; k < 4; k++) begin
      total++; if (sel !== 2'(k)) $display("FAIL basic_sel got %0d exp %0d", sel, k); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL basic_busy_scan got %b exp 1", busy); else passed++;
      if (out_valid) pulses++;
      step(1'b0);
    end
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_done busy=%b valid=%b exp 1/0", busy, out_valid); else passed++;
    step(1'b0);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", out_valid); else passed++;
    total++; if (out !== exp_out) $display("FAIL basic_out got %0d exp %0d", out, exp_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b exp 0", busy); else passed++;
    if (out_valid) pulses++;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      if (out_valid) pulses++;
    end
    total++; if (pulses !== 1) $display("FAIL basic_pulses got %0d exp 1", pulses); else passed++;
    total++; if (out !== exp_out) $display("FAIL basic_hold got %0d exp %0d", out, exp_out); else passed++;
  endtask

  task automatic test_masking;
    logic [11:0] exp_out;
`ifdef VOICE_MIXER_SAT_EN
    exp_out = 12'd4000;
`else
    exp_out = 12'd1000;
`endif
    set_voices(1000, 4000, 3000, 4000);
    voice_en = 4'b0101;
    step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    total++; if (out_valid !== 1'b1 || out !== exp_out) $display("FAIL mask_out got %0d valid=%b exp %0d", out, out_valid, exp_out); else passed++;
    step(1'b0);
  endtask

  task automatic test_saturation;
    set_voices(4095, 4095, 4095, 4095);
    voice_en = 4'b1111;
    step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    total++; if (out_valid !== 1'b1 || out !== 12'd4095) $display("FAIL sat_out got %0d valid=%b exp 4095", out, out_valid); else passed++;
    step(1'b0);
  endtask

  task automatic test_enable_change;
    logic [11:0] exp_out;
`ifdef VOICE_MIXER_SAT_EN
    exp_out = 12'd100;
`else
    exp_out = 12'd25;
`endif
    set_voices(100, 200, 300, 400);
    voice_en = 4'b1111;
    step(1'b1);
    step(1'b0);
    voice_en = 4'b0000;
    for (int k = 0; k < 4; k++) step(1'b0);
    total++; if (out_valid !== 1'b1 || out !== exp_out) $display("FAIL en_change_out got %0d valid=%b exp %0d", out, out_valid, exp_out); else passed++;
    voice_en = 4'b1111;
    step(1'b0);
  endtask

  task automatic test_overrun;
    logic [11:0] exp_out;
    int pulses;
`ifdef VOICE_MIXER_SAT_EN
    exp_out = 12'd1000;
`else
    exp_out = 12'd250;
`endif
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    set_voices(100, 200, 300, 400);
    voice_en = 4'b1111;
    pulses = 0;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    total++; if (overrun !== 1'b0) $display("FAIL overrun_early got %b exp 0", overrun); else passed++;
    step(1'b1);
    if (out_valid) pulses++;
    step(1'b0);
    total++; if (overrun !== 1'b1) $display("FAIL overrun_set got %b exp 1", overrun); else passed++;
    if (out_valid) pulses++;
    step(1'b0);
    total++; if (out_valid !== 1'b1 || out !== exp_out) $display("FAIL overrun_frame got %0d valid=%b exp %0d", out, out_valid, exp_out); else passed++;
    if (out_valid) pulses++;
    step(1'b1);
    if (out_valid) pulses++;
    total++; if (pulses !== 1) $display("FAIL overrun_pulses got %0d exp 1", pulses); else passed++;
    total++; if (busy !== 1'b1 || sel !== 2'd0) $display("FAIL overrun_restart busy=%b sel=%0d exp 1/0", busy, sel); else passed++;
    for (int k = 0; k < 5; k++) step(1'b0);
    total++; if (out_valid !== 1'b1 || overrun !== 1'b1) $display("FAIL overrun_held valid=%b overrun=%b exp 1/1", out_valid, overrun); else passed++;
    step(1'b0);
  endtask

  task automatic test_done_tick;
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    voice_en = 4'b1111;
    step(1'b1);
    for (int k = 0; k < 3; k++) step(1'b0);
    step(1'b0);
    total++; if (overrun !== 1'b0 || busy !== 1'b1) $display("FAIL done_tick_pre overrun=%b busy=%b exp 0/1", overrun, busy); else passed++;
    step(1'b1);
    total++; if (overrun !== 1'b1 || out_valid !== 1'b1) $display("FAIL done_tick overrun=%b valid=%b exp 1/1", overrun, out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL done_tick_no_start got busy %b exp 0", busy); else passed++;
    step(1'b0);
  endtask

  task automatic test_reset_midframe;
    logic [11:0] exp_out;
`ifdef VOICE_MIXER_SAT_EN
    exp_out = 12'd400;
`else
    exp_out = 12'd100;
`endif
    set_voices(4000, 4000, 4000, 4000);
    voice_en = 4'b1111;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    total++; if (sel !== 2'd2) $display("FAIL rst_mid_sel got %0d exp 2", sel); else passed++;
    rst_n = 1'b0;
    step(1'b0);
    total++; if (sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_mid_state sel=%0d busy=%b valid=%b exp 0/0/0", sel, busy, out_valid); else passed++;
    total++; if (out !== 12'd0 || overrun !== 1'b0) $display("FAIL rst_mid_out out=%0d overrun=%b exp 0/0", out, overrun); else passed++;
    rst_n = 1'b1;
    step(1'b0);
    set_voices(40, 80, 120, 160);
    step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    total++; if (out_valid !== 1'b1 || out !== exp_out) $display("FAIL rst_mid_fresh got %0d valid=%b exp %0d", out, out_valid, exp_out); else passed++;
    step(1'b0);
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    voice_en    = 4'b0000;
    set_voices(0, 0, 0, 0);
    test_reset;
    test_basic;
    test_masking;
    test_saturation;
    test_enable_change;
    test_overrun;
    test_done_tick;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
